// File: rtl/dbc_pkg.sv
// rtl/dbc_pkg.sv - shared constants, request record and lane helpers for data_bus_ram_ctrl
package dbc_pkg;

  localparam logic [1:0] SZ_BYTE    = 2'b00;
  localparam logic [1:0] SZ_HALF    = 2'b01;
  localparam logic [1:0] SZ_WORD    = 2'b10;
  localparam logic [1:0] SZ_ILLEGAL = 2'b11;

  localparam logic [1:0] ST_IDLE   = 2'b00;
  localparam logic [1:0] ST_ACCESS = 2'b01;
  localparam logic [1:0] ST_RESP   = 2'b10;

  localparam logic [3:0] REG_STATUS     = 4'h0;
  localparam logic [3:0] REG_FAULT_ADDR = 4'h4;
  localparam logic [3:0] REG_IRQ_EN     = 4'h8;
  localparam logic [3:0] REG_ID         = 4'hC;

  localparam int STS_MISALIGN = 0;
  localparam int STS_UNMAPPED = 1;
  localparam int STS_ILLEGAL  = 2;

  localparam logic [31:0] DBC_ID = 32'h4442_4302;

  typedef struct packed {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
  } dbc_req_t;

  function automatic logic [3:0] lane_enables(input logic [1:0] size, input logic [1:0] lo);
    case (size)
      SZ_BYTE: lane_enables = 4'b0001 << lo;
      SZ_HALF: lane_enables = lo[1] ? 4'b1100 : 4'b0011;
      default: lane_enables = 4'b1111;
    endcase
  endfunction

  // Store data is replicated so every enabled lane sees the right bytes.
  function automatic logic [31:0] lane_data(input logic [1:0] size, input logic [31:0] d);
    case (size)
      SZ_BYTE: lane_data = {4{d[7:0]}};
      SZ_HALF: lane_data = {2{d[15:0]}};
      default: lane_data = d;
    endcase
  endfunction

endpackage

// File: rtl/dbc_ram_bank.sv
// rtl/dbc_ram_bank.sv - single-port synchronous RAM, 32-bit words, byte enables, 1-cycle read
module dbc_ram_bank #(
  parameter int WORDS = 1024,
  parameter int AW    = 10
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [3:0]    be,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] mem [WORDS];

  // Read-before-write: rdata shows the word as it was before this edge's write.
  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < 4; i++) begin
        if (we && be[i]) mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
      end
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/data_bus_ram_ctrl.sv
// rtl/data_bus_ram_ctrl.sv - three-phase data bus controller for a local RAM and a 16-byte register window
module data_bus_ram_ctrl
  import dbc_pkg::*;
#(
  parameter int          RAM_WORDS = 1024,
  parameter logic [31:0] RAM_BASE  = 32'h0000_1000,
  parameter logic [31:0] REG_BASE  = 32'h0000_0F00
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        uns,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        ack,
  output logic        busy,
  output logic        err,
  output logic        irq
);

  localparam int AW = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
  localparam logic [32:0] RAM_LO = {1'b0, RAM_BASE};
  localparam logic [32:0] RAM_HI = {1'b0, RAM_BASE} + 33'(RAM_WORDS) * 33'd4;
  localparam logic [32:0] REG_LO = {1'b0, REG_BASE};
  localparam logic [32:0] REG_HI = {1'b0, REG_BASE} + 33'd16;

  logic [1:0]  state;
  dbc_req_t    cur;
  logic [2:0]  status;
  logic [2:0]  irq_en;
  logic [31:0] fault_addr;

  logic [32:0] addr_ext;
  logic        ram_hit, reg_hit;
  logic [2:0]  flt;
  logic        fault;
  logic [31:0] ram_off;
  logic [3:0]  reg_off;
  logic [3:0]  reg_sel;
  logic        ram_en;
  logic [31:0] ram_rdata;
  logic [31:0] reg_rd, ram_ext, load_val;
  logic [7:0]  lane8;
  logic [15:0] lane16;
  logic        unused_ok;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      cur   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req) begin
            state <= ST_ACCESS;
            cur   <= '{we: we, size: size, uns: uns, addr: addr, wdata: wdata};
          end
        end
        ST_ACCESS: state <= ST_RESP;
        default:   state <= ST_IDLE;
      endcase
    end
  end

  assign addr_ext = {1'b0, cur.addr};
  assign ram_hit  = (addr_ext >= RAM_LO) && (addr_ext < RAM_HI);
  assign reg_hit  = (addr_ext >= REG_LO) && (addr_ext < REG_HI);
  assign ram_off  = cur.addr - RAM_BASE;
  assign reg_off  = cur.addr[3:0] - REG_BASE[3:0];
  assign reg_sel  = {reg_off[3:2], 2'b00};

  always_comb begin
    flt = '0;
    flt[STS_MISALIGN] = ((cur.size == SZ_HALF) && cur.addr[0]) ||
                        ((cur.size == SZ_WORD) && (cur.addr[1:0] != 2'b00)) ||
                        (reg_hit && (cur.size != SZ_WORD));
    flt[STS_UNMAPPED] = !ram_hit && !reg_hit;
    flt[STS_ILLEGAL]  = (cur.size == SZ_ILLEGAL);
  end
  assign fault = |flt;

  // Faulted accesses never touch the bank, so writes are suppressed at the source.
  assign ram_en = (state == ST_ACCESS) && ram_hit && !fault;

  dbc_ram_bank #(.WORDS(RAM_WORDS), .AW(AW)) u_bank (
    .clk   (clk),
    .en    (ram_en),
    .we    (cur.we),
    .be    (lane_enables(cur.size, cur.addr[1:0])),
    .addr  (ram_off[AW+1:2]),
    .wdata (lane_data(cur.size, cur.wdata)),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      status     <= '0;
      irq_en     <= '0;
      fault_addr <= '0;
    end else if (state == ST_ACCESS) begin
      if (fault) begin
        status     <= status | flt;
        fault_addr <= cur.addr;
      end else if (reg_hit && cur.we) begin
        if (reg_sel == REG_STATUS) status <= status & ~cur.wdata[2:0];
        if (reg_sel == REG_IRQ_EN) irq_en <= cur.wdata[2:0];
      end
    end
  end

  always_comb begin
    case (reg_sel)
      REG_STATUS:     reg_rd = {29'b0, status};
      REG_FAULT_ADDR: reg_rd = fault_addr;
      REG_IRQ_EN:     reg_rd = {29'b0, irq_en};
      REG_ID:         reg_rd = DBC_ID;
      default:        reg_rd = '0;
    endcase
  end

  always_comb begin
    case (cur.addr[1:0])
      2'd0:    lane8 = ram_rdata[7:0];
      2'd1:    lane8 = ram_rdata[15:8];
      2'd2:    lane8 = ram_rdata[23:16];
      default: lane8 = ram_rdata[31:24];
    endcase
    lane16 = cur.addr[1] ? ram_rdata[31:16] : ram_rdata[15:0];
    case (cur.size)
      SZ_BYTE: ram_ext = {{24{~cur.uns & lane8[7]}}, lane8};
      SZ_HALF: ram_ext = {{16{~cur.uns & lane16[15]}}, lane16};
      default: ram_ext = ram_rdata;
    endcase
  end

  assign load_val = reg_hit ? reg_rd : ram_ext;

  assign ack   = (state == ST_RESP);
  assign busy  = (state != ST_IDLE);
  assign err   = ack && fault;
  assign rdata = (ack && !cur.we && !fault) ? load_val : 32'h0;
  assign irq   = |(status & irq_en);

  assign unused_ok = &{1'b0, ram_off[31:AW+2], ram_off[1:0], reg_off[1:0]};

endmodule

// File: doc/data_bus_ram_ctrl.md
DATA_BUS_RAM_CTRL -- requirements
Module: data_bus_ram_ctrl

Interface
REQ-001 SHALL have parameter RAM_WORDS, default 1024: RAM depth in 32-bit words, power of two.
REQ-002 SHALL have parameter RAM_BASE, default 32'h0000_1000: byte address of RAM word 0.
REQ-003 SHALL have parameter REG_BASE, default 32'h0000_0F00: base of the 16-byte register window.
REQ-004 SHALL have port clk, input, 1: single clock, rising edge.
REQ-005 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have port req, input, 1: access request, sampled only in IDLE.
REQ-007 SHALL have port we, input, 1: 1 = write, 0 = read.
REQ-008 SHALL have port size, input, 2: 00 byte, 01 half, 10 word, 11 illegal.
REQ-009 SHALL have port uns, input, 1: zero-extend loads when 1, sign-extend when 0.
REQ-010 SHALL have port addr, input, 32: byte address.
REQ-011 SHALL have port wdata, input, 32: store data, right-justified.
REQ-012 SHALL have port rdata, output, 32: load data, valid only while ack=1, else 0.
REQ-013 SHALL have port ack, output, 1: one-cycle completion pulse.
REQ-014 SHALL have port busy, output, 1: request in progress.
REQ-015 SHALL have port err, output, 1: faulted access, pulses with ack.
REQ-016 SHALL have port irq, output, 1: level, equals |(STATUS & IRQ_EN).

Function
REQ-017 SHALL run an FSM IDLE -> ACCESS -> RESP -> IDLE: IDLE->ACCESS on req; ACCESS->RESP and RESP->IDLE unconditionally.
REQ-018 SHALL latch we/size/uns/addr/wdata on the accepting edge and ignore inputs while busy.
REQ-019 SHALL drive busy=1 in ACCESS and RESP, and ack=1 only in RESP, giving an accept-to-ack latency of 2 cycles and one access per 3 cycles.
REQ-020 SHALL decode RAM hits as RAM_BASE <= addr < RAM_BASE+4*RAM_WORDS, with word index (addr-RAM_BASE)>>2.
REQ-021 SHALL decode register hits as REG_BASE <= addr < REG_BASE+16; every other address is unmapped.
REQ-022 SHALL flag as misaligned: half with addr[0]=1, word with addr[1:0]!=0, and any register access with size!=10.
REQ-023 SHALL commit RAM writes on the ACCESS->RESP edge using byte enables: byte -> lane addr[1:0], half -> lanes {addr[1],0..1}, word -> all lanes; unaddressed lanes are unchanged.
REQ-024 SHALL extract RAM loads from the same lane, then sign- or zero-extend them per uns; uns is ignored for word loads.
REQ-025 SHALL implement register +0 STATUS: bit0 misaligned, bit1 unmapped, bit2 illegal size; sticky; write-1-to-clear.
REQ-026 SHALL implement register +4 FAULT_ADDR (read-only, address of the last faulting access), +8 IRQ_EN (rw, bits 2:0, other bits read 0), and +C ID (read-only, 32'h4442_4302).
REQ-027 SHALL, on a fault: suppress all writes, return rdata=0, pulse err with ack, set the matching STATUS bit(s), and load FAULT_ADDR at the ACCESS->RESP edge.
REQ-028 SHALL set bit2 only when size=11; bit0 and bit1 may both set on one access.
REQ-029 SHALL treat register writes to read-only offsets as silently ignored, with no fault.

Reset
REQ-030 SHALL, while rst=1, force state=IDLE, ack=0, busy=0, err=0, rdata=0, STATUS=0, FAULT_ADDR=0, IRQ_EN=0 (irq=0).
REQ-031 SHALL leave RAM contents undefined on reset and never clear them.
REQ-032 SHALL discard an access interrupted by reset before the ACCESS->RESP edge, with no memory write and no ack.

Structure
REQ-033 SHALL take size codes, FSM state encoding, register offsets, STATUS bit indices and the ID constant from shared package dbc_pkg.
REQ-034 SHALL instantiate one sub-module dbc_ram_bank: a synchronous single-port RAM, RAM_WORDS x 32, with 4 byte enables and a 1-cycle read.

Verification
REQ-035 SHALL cover: word write 32'hDEADBEEF @RAM_BASE, then byte write 8'h11 @RAM_BASE+2, then word read -> rdata=32'hDE11BEEF, ack exactly 2 cycles after accept, err=0.
REQ-036 SHALL cover: byte 8'h80 @RAM_BASE+1, then byte read with uns=0 -> 32'hFFFFFF80, and with uns=1 -> 32'h00000080.
REQ-037 SHALL cover: half write @RAM_BASE+1 -> err=1, RAM unchanged, STATUS=3'b001, FAULT_ADDR=RAM_BASE+1; then write 1 to STATUS -> STATUS=0.
REQ-038 SHALL cover: read @32'h0000_0000 with IRQ_EN=3'b010 -> err=1, rdata=0, STATUS bit1=1, irq=1.
REQ-039 SHALL cover: read ID -> 32'h4442_4302; req held high continuously -> accepts spaced exactly 3 cycles apart.
REQ-040 SHALL cover: rst asserted during ACCESS of a word write -> no ack, target word unchanged, all outputs 0 immediately, without waiting for a clk edge.
